// File: rtl/cpu_ctrl_pkg.sv
// Shared mode codes, sequencer state encoding and the mode-to-state mapping
// for the CPU clock-enable / reset sequencer.
package cpu_ctrl_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_HALT = 2'b10;

    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_e;

    // Mode 11 is reserved and behaves like HALT.
    function automatic state_e mode_target(input logic [1:0] mode);
        case (mode)
            MODE_RUN:  return S_RUN;
            MODE_STEP: return S_STEP;
            default:   return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/cpu_clk_rst_ctrl_if.sv
// Control/status bundle between the board-side controller (master) and the
// clock-enable / reset sequencer (slave).
interface cpu_clk_rst_ctrl_if #(
    parameter int DIV_W  = 8,
    parameter int STEP_W = 16
);
    logic [1:0]        mode;
    logic [DIV_W-1:0]  div;
    logic              step_req;
    logic [STEP_W-1:0] step_cnt;
    logic              step_done;
    logic              busy;
    logic              cpu_rst;
    logic              cpu_ce;
    logic [31:0]       ce_count;

    modport master (
        output mode, div, step_req, step_cnt,
        input  step_done, busy, cpu_rst, cpu_ce, ce_count
    );

    modport slave (
        input  mode, div, step_req, step_cnt,
        output step_done, busy, cpu_rst, cpu_ce, ce_count
    );
endinterface

// File: rtl/ce_divider.sv
// Free-running enable divider: tick every div_reg+1 cycles; a new divide value
// is adopted only on a tick so the current period always completes.
module ce_divider #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 49
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_reg_q, div_reg_d;

    // >= rather than == so a shrunk divide value cannot strand the counter above it.
    always_comb begin
        tick      = (div_cnt_q >= div_reg_q);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        div_reg_d = tick ? div : div_reg_q;
    end

    // NOTE: flops use <= so every register updates from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            div_reg_q <= DIV_W'(DIV_RST);
        end else begin
            div_cnt_q <= div_cnt_d;
            div_reg_q <= div_reg_d;
        end
    end

endmodule

// File: rtl/cpu_clk_rst_ctrl.sv
// Clock-enable and reset sequencer for CPUCORE: holds the core in reset for RST_HOLD
// enables, then issues divided enables in run, counted-step or halt mode.
module cpu_clk_rst_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RST_HOLD = 5,
    parameter int DIV_W    = 8,
    parameter int DIV_RST  = 49,
    parameter int STEP_W   = 16
) (
    input logic               clk,
    input logic               rst,
    cpu_clk_rst_ctrl_if.slave bus
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    state_e            state_q, state_d;
    state_e            target;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic              busy_q, busy_d;
    logic              step_done_q, step_done_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              cpu_ce_q, cpu_ce_d;
    logic [31:0]       ce_count_q, ce_count_d;
    logic              tick;

    ce_divider #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .div  (bus.div),
        .tick (tick)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        steps_left_d = steps_left_q;
        busy_d       = busy_q;
        step_done_d  = 1'b0;
        cpu_rst_d    = cpu_rst_q;
        cpu_ce_d     = 1'b0;
        ce_count_d   = ce_count_q;
        target       = mode_target(bus.mode);

        case (state_q)
            S_HOLD: begin
                // The release cycle issues no enable, so the core never sees an edge mid-release.
                if (hold_cnt_q == HOLD_W'(RST_HOLD)) begin
                    cpu_rst_d = 1'b0;
                    state_d   = target;
                end else if (tick) begin
                    cpu_ce_d   = 1'b1;
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN: cpu_ce_d = tick;
            S_STEP: begin
                if (steps_left_q == '0) begin
                    if (bus.step_req) begin
                        steps_left_d = (bus.step_cnt == '0) ? STEP_W'(1) : bus.step_cnt;
                        busy_d       = 1'b1;
                    end
                end else if (tick) begin
                    cpu_ce_d     = 1'b1;
                    steps_left_d = steps_left_q - STEP_W'(1);
                    if (steps_left_q == STEP_W'(1)) begin
                        step_done_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // Mode is registered: it picks next cycle's state; entering RUN abandons any burst.
        if (state_q != S_HOLD) begin
            state_d = target;
            if (target == S_RUN) begin
                steps_left_d = '0;
                busy_d       = 1'b0;
                step_done_d  = 1'b0;
            end
        end

        if (cpu_ce_d && state_q != S_HOLD) begin
            ce_count_d = ce_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= '0;
            steps_left_q <= '0;
            busy_q       <= 1'b0;
            step_done_q  <= 1'b0;
            cpu_rst_q    <= 1'b1;
            cpu_ce_q     <= 1'b0;
            ce_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            steps_left_q <= steps_left_d;
            busy_q       <= busy_d;
            step_done_q  <= step_done_d;
            cpu_rst_q    <= cpu_rst_d;
            cpu_ce_q     <= cpu_ce_d;
            ce_count_q   <= ce_count_d;
        end
    end

    assign bus.step_done = step_done_q;
    assign bus.busy      = busy_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.ce_count  = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_rst_ctrl.sv
// Scoreboard bench for cpu_clk_rst_ctrl: every expected cpu_ce (cycle, cpu_rst, ce_count)
// is queued by the scenario tasks and matched by a monitor against each observed pulse.
module tb_cpu_clk_rst_ctrl;
    import cpu_ctrl_pkg::*;

    typedef struct {
        int          cyc;
        logic        rst;
        logic [31:0] cnt;
    } ce_exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      cyc = 0;
    int      total = 0;
    int      bad = 0;
    ce_exp_t ce_q[$];
    ce_exp_t e;

    cpu_clk_rst_ctrl_if #(.DIV_W(8), .STEP_W(16)) bus ();

    cpu_clk_rst_ctrl #(
        .RST_HOLD (5),
        .DIV_W    (8),
        .DIV_RST  (49),
        .STEP_W   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Every observed enable must match the head of the expectation queue.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (bus.cpu_ce === 1'b1) begin
            total++;
            if (ce_q.size() == 0) begin
                bad++;
                $display("FAIL ce_unexpected: got ce at cyc=%0d, want none", cyc);
            end else begin
                e = ce_q.pop_front();
                if (cyc !== e.cyc || bus.cpu_rst !== e.rst || bus.ce_count !== e.cnt) begin
                    bad++;
                    $display("FAIL ce_event: got cyc=%0d rst=%b cnt=%h, want cyc=%0d rst=%b cnt=%h",
                             cyc, bus.cpu_rst, bus.ce_count, e.cyc, e.rst, e.cnt);
                end
            end
        end
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic goto_cyc(input int c);
        if (c > cyc) begin
            repeat (c - cyc) @(posedge clk);
            #2;
        end
    endtask

    task automatic push_ce(input int c, input logic r, input logic [31:0] n);
        ce_q.push_back('{cyc: c, rst: r, cnt: n});
    endtask

    // Reset with a fixed mode/div; queues the five hold enables (first period is DIV_RST+1).
    task automatic reset_dut(input logic [1:0] m, input logic [7:0] d, output int r);
        int p;
        bus.mode     = m;
        bus.div      = d;
        bus.step_req = 1'b0;
        bus.step_cnt = '0;
        rst = 1'b1;
        step_clk(2);
        rst = 1'b0;
        r = cyc;
        p = int'(d) + 1;
        for (int k = 0; k < 5; k++) push_ce(r + 50 + k * p, 1'b1, 32'd0);
    endtask

    task automatic test_reset();
        int r;
        bus.mode = MODE_RUN; bus.div = 8'd0; bus.step_req = 1'b0; bus.step_cnt = '0;
        rst = 1'b1;
        step_clk(2);
        total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst: got %b want 1", bus.cpu_rst); end
        total++; if (bus.cpu_ce !== 1'b0) begin bad++; $display("FAIL rst_cpu_ce: got %b want 0", bus.cpu_ce); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.step_done !== 1'b0) begin bad++; $display("FAIL rst_step_done: got %b want 0", bus.step_done); end
        total++; if (bus.ce_count !== 32'd0) begin bad++; $display("FAIL rst_ce_count: got %h want 0", bus.ce_count); end
        rst = 1'b0;
        r = cyc;
        for (int k = 0; k < 5; k++) push_ce(r + 50 + k, 1'b1, 32'd0);
        for (int n = 1; n <= 10; n++) push_ce(r + 55 + n, 1'b0, 32'(n));
        goto_cyc(r + 54);
        total++; if (bus.cpu_rst !== 1'b1) begin bad++; $display("FAIL hold_last_rst: got %b want 1", bus.cpu_rst); end
        goto_cyc(r + 55);
        total++; if (bus.cpu_rst !== 1'b0 || bus.cpu_ce !== 1'b0) begin
            bad++; $display("FAIL hold_release: got rst=%b ce=%b want rst=0 ce=0", bus.cpu_rst, bus.cpu_ce);
        end
        goto_cyc(r + 65);
        total++; if (bus.ce_count !== 32'd10) begin bad++; $display("FAIL run_count10: got %0d want 10", bus.ce_count); end
        bus.mode = MODE_HALT;
        push_ce(r + 66, 1'b0, 32'd11);
        goto_cyc(r + 70);
        total++; if (ce_q.size() != 0) begin bad++; $display("FAIL reset_drain: got %0d pending ce, want 0", ce_q.size()); ce_q.delete(); end
    endtask

    task automatic test_divider();
        int r;
        reset_dut(MODE_RUN, 8'd49, r);
        push_ce(r + 300, 1'b0, 32'd1);
        push_ce(r + 350, 1'b0, 32'd2);
        goto_cyc(r + 251);
        total++; if (bus.cpu_rst !== 1'b0) begin bad++; $display("FAIL div_release: got %b want 0", bus.cpu_rst); end
        goto_cyc(r + 320);
        bus.div = 8'd3;
        push_ce(r + 354, 1'b0, 32'd3);
        push_ce(r + 358, 1'b0, 32'd4);
        push_ce(r + 362, 1'b0, 32'd5);
        goto_cyc(r + 362);
        bus.mode = MODE_HALT;
        goto_cyc(r + 370);
        total++; if (ce_q.size() != 0) begin bad++; $display("FAIL div_drain: got %0d pending ce, want 0", ce_q.size()); ce_q.delete(); end
    endtask

    task automatic test_step();
        int r;
        reset_dut(MODE_STEP, 8'd1, r);
        goto_cyc(r + 60);
        bus.step_cnt = 16'd3; bus.step_req = 1'b1;
        push_ce(r + 62, 1'b0, 32'd1);
        push_ce(r + 64, 1'b0, 32'd2);
        push_ce(r + 66, 1'b0, 32'd3);
        goto_cyc(r + 61);
        bus.step_req = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL step_busy_set: got %b want 1", bus.busy); end
        goto_cyc(r + 65);
        total++; if (bus.step_done !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL step_mid: got done=%b busy=%b want done=0 busy=1", bus.step_done, bus.busy);
        end
        goto_cyc(r + 66);
        total++; if (bus.step_done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL step_done3: got done=%b busy=%b want done=1 busy=0", bus.step_done, bus.busy);
        end
        goto_cyc(r + 67);
        total++; if (bus.step_done !== 1'b0) begin bad++; $display("FAIL step_done_pulse: got %b want 0", bus.step_done); end
        goto_cyc(r + 70);
        bus.step_cnt = 16'd0; bus.step_req = 1'b1;
        push_ce(r + 72, 1'b0, 32'd4);
        goto_cyc(r + 71);
        bus.step_req = 1'b0;
        goto_cyc(r + 72);
        total++; if (bus.step_done !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL step_zero_done: got done=%b busy=%b want done=1 busy=0", bus.step_done, bus.busy);
        end
        goto_cyc(r + 76);
        total++; if (ce_q.size() != 0) begin bad++; $display("FAIL step_drain: got %0d pending ce, want 0", ce_q.size()); ce_q.delete(); end
    endtask

    task automatic test_halt_resume();
        int r;
        int viol;
        reset_dut(MODE_STEP, 8'd1, r);
        goto_cyc(r + 60);
        bus.step_cnt = 16'd10; bus.step_req = 1'b1;
        for (int n = 1; n <= 4; n++) push_ce(r + 60 + 2 * n, 1'b0, 32'(n));
        goto_cyc(r + 61);
        bus.step_req = 1'b0;
        goto_cyc(r + 68);
        bus.mode = MODE_HALT;
        viol = 0;
        for (int c = r + 69; c <= r + 88; c++) begin
            goto_cyc(c);
            if (bus.busy !== 1'b1 || bus.cpu_ce !== 1'b0 || bus.step_done !== 1'b0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL halt_hold: got %0d bad cycles want 0", viol); end
        bus.mode = MODE_STEP;
        for (int n = 5; n <= 10; n++) push_ce(r + 80 + 2 * n, 1'b0, 32'(n));
        goto_cyc(r + 99);
        total++; if (bus.busy !== 1'b1 || bus.step_done !== 1'b0) begin
            bad++; $display("FAIL resume_mid: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.step_done);
        end
        goto_cyc(r + 100);
        total++; if (bus.busy !== 1'b0 || bus.step_done !== 1'b1) begin
            bad++; $display("FAIL resume_done: got busy=%b done=%b want busy=0 done=1", bus.busy, bus.step_done);
        end
        goto_cyc(r + 104);
        total++; if (ce_q.size() != 0) begin bad++; $display("FAIL resume_drain: got %0d pending ce, want 0", ce_q.size()); ce_q.delete(); end
    endtask

    task automatic test_halt_to_run();
        int r;
        int dones;
        reset_dut(MODE_STEP, 8'd1, r);
        goto_cyc(r + 60);
        bus.step_cnt = 16'd10; bus.step_req = 1'b1;
        for (int n = 1; n <= 4; n++) push_ce(r + 60 + 2 * n, 1'b0, 32'(n));
        goto_cyc(r + 61);
        bus.step_req = 1'b0;
        goto_cyc(r + 68);
        bus.mode = MODE_HALT;
        goto_cyc(r + 88);
        bus.mode = MODE_RUN;
        for (int n = 5; n <= 8; n++) push_ce(r + 80 + 2 * n, 1'b0, 32'(n));
        goto_cyc(r + 89);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL torun_busy: got %b want 0", bus.busy); end
        dones = 0;
        for (int c = r + 90; c <= r + 100; c++) begin
            goto_cyc(c);
            if (c == r + 95) bus.mode = MODE_HALT;
            if (bus.step_done !== 1'b0) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL torun_no_done: got %0d pulses want 0", dones); end
        total++; if (ce_q.size() != 0) begin bad++; $display("FAIL torun_drain: got %0d pending ce, want 0", ce_q.size()); ce_q.delete(); end
    endtask

    task automatic test_async_reset();
        int r;
        int dones;
        reset_dut(MODE_RUN, 8'd0, r);
        for (int n = 1; n <= 5; n++) push_ce(r + 55 + n, 1'b0, 32'(n));
        goto_cyc(r + 60);
        rst = 1'b1;
        #1;
        total++; if (bus.cpu_rst !== 1'b1 || bus.cpu_ce !== 1'b0 || bus.ce_count !== 32'd0) begin
            bad++; $display("FAIL arst_run: got rst=%b ce=%b cnt=%h want rst=1 ce=0 cnt=0", bus.cpu_rst, bus.cpu_ce, bus.ce_count);
        end
        reset_dut(MODE_STEP, 8'd1, r);
        goto_cyc(r + 60);
        bus.step_cnt = 16'd10; bus.step_req = 1'b1;
        push_ce(r + 62, 1'b0, 32'd1);
        push_ce(r + 64, 1'b0, 32'd2);
        goto_cyc(r + 61);
        bus.step_req = 1'b0;
        goto_cyc(r + 65);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1 || bus.ce_count !== 32'd0 || bus.step_done !== 1'b0) begin
            bad++; $display("FAIL arst_burst: got busy=%b rst=%b cnt=%h done=%b want 0 1 0 0",
                            bus.busy, bus.cpu_rst, bus.ce_count, bus.step_done);
        end
        dones = 0;
        for (int c = r + 66; c <= r + 75; c++) begin
            goto_cyc(c);
            if (bus.step_done !== 1'b0 || bus.busy !== 1'b0) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL arst_lost_burst: got %0d bad cycles want 0", dones); end
        total++; if (ce_q.size() != 0) begin bad++; $display("FAIL arst_drain: got %0d pending ce, want 0", ce_q.size()); ce_q.delete(); end
    endtask

    task automatic test_wrap();
        int r;
        reset_dut(MODE_RUN, 8'd0, r);
        for (int n = 1; n <= 5; n++) push_ce(r + 55 + n, 1'b0, 32'(n));
        goto_cyc(r + 60);
        force dut.ce_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.ce_count_q;
        push_ce(r + 61, 1'b0, 32'd0);
        goto_cyc(r + 61);
        total++; if (bus.ce_count !== 32'd0) begin bad++; $display("FAIL wrap_zero: got %h want 0", bus.ce_count); end
        push_ce(r + 62, 1'b0, 32'd1);
        goto_cyc(r + 62);
        bus.mode = MODE_HALT;
        push_ce(r + 63, 1'b0, 32'd2);
        goto_cyc(r + 67);
        total++; if (ce_q.size() != 0) begin bad++; $display("FAIL wrap_drain: got %0d pending ce, want 0", ce_q.size()); ce_q.delete(); end
    endtask

    initial begin
        bus.mode     = MODE_RUN;
        bus.div      = 8'd0;
        bus.step_req = 1'b0;
        bus.step_cnt = '0;
        test_reset();
        test_divider();
        test_step();
        test_halt_resume();
        test_halt_to_run();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
